// File: rtl/hazard_pkg.sv
// +----------------------------------------------------------------------------+
// | hazard_pkg                                                                 |
// | Opcode constants and register-usage encoding for the hazard scoreboard.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_ialu   = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic is_load;
  } usage_t;

  // Unknown opcodes read and write nothing, so they can never stall or mark busy.
  function automatic usage_t decode_usage(input logic [6:0] opcode);
    usage_t u;
    u = '0;
    case (opcode)
      c_op_rtype: begin
        u.uses_rs1  = 1'b1;
        u.uses_rs2  = 1'b1;
        u.writes_rd = 1'b1;
      end
      c_op_store, c_op_branch: begin
        u.uses_rs1 = 1'b1;
        u.uses_rs2 = 1'b1;
      end
      c_op_ialu, c_op_jalr: begin
        u.uses_rs1  = 1'b1;
        u.writes_rd = 1'b1;
      end
      c_op_load: begin
        u.uses_rs1  = 1'b1;
        u.writes_rd = 1'b1;
        u.is_load   = 1'b1;
      end
      c_op_jal, c_op_lui, c_op_auipc: begin
        u.writes_rd = 1'b1;
      end
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_src_decode.sv
// +----------------------------------------------------------------------------+
// | hazard_src_decode                                                          |
// | Maps a decode-stage opcode to its source/destination register usage.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_src_decode
  import hazard_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_load
);

  usage_t w_use;

  assign w_use     = decode_usage(opcode);
  assign uses_rs1  = w_use.uses_rs1;
  assign uses_rs2  = w_use.uses_rs2;
  assign writes_rd = w_use.writes_rd;
  assign is_load   = w_use.is_load;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// +----------------------------------------------------------------------------+
// | hazard_scoreboard                                                          |
// | Per-register latency scoreboard producing stall/flush/issue for decode.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_scoreboard #(
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int ALU_LAT      = 3,
  parameter int LOAD_LAT     = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            branch_taken,
  output logic            stall,
  output logic            flush,
  output logic            issue,
  output logic [NREG-1:0] busy_vec,
  output logic [15:0]     stall_count
);

  localparam int c_max_lat = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int c_cw      = (c_max_lat < 1) ? 1 : $clog2(c_max_lat + 1);
  localparam int c_fw      = (FLUSH_CYCLES <= 1) ? 1 : $clog2(FLUSH_CYCLES);

  localparam logic [c_cw-1:0] c_alu_lat      = c_cw'(ALU_LAT);
  localparam logic [c_cw-1:0] c_load_lat     = c_cw'(LOAD_LAT);
  localparam logic [c_fw-1:0] c_flush_reload = c_fw'(FLUSH_CYCLES - 1);

  logic w_uses_rs1;
  logic w_uses_rs2;
  logic w_writes_rd;
  logic w_is_load;

  hazard_src_decode u_decode (
    .opcode    (id_opcode),
    .uses_rs1  (w_uses_rs1),
    .uses_rs2  (w_uses_rs2),
    .writes_rd (w_writes_rd),
    .is_load   (w_is_load)
  );

  // Widen the busy flags to the full index space so any id_rs* value is a legal index.
  logic [(1<<AW)-1:0] w_busy_full;

  always_comb begin
    w_busy_full           = '0;
    w_busy_full[NREG-1:0] = busy_vec;
  end

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = w_uses_rs1 && (id_rs1 != '0) && w_busy_full[id_rs1];
  assign w_rs2_hit = w_uses_rs2 && (id_rs2 != '0) && w_busy_full[id_rs2];

  logic [c_fw-1:0] r_flush_cnt;

  // Reset masks flush so a stray branch_taken cannot kill decode while in reset.
  assign flush = ~rst & (branch_taken | (r_flush_cnt != '0));
  assign stall = id_valid & ~flush & (w_rs1_hit | w_rs2_hit);
  assign issue = id_valid & ~stall & ~flush;

  logic [c_cw-1:0] w_lat;
  logic            w_set;

  assign w_lat = w_is_load ? c_load_lat : c_alu_lat;
  assign w_set = issue & w_writes_rd & (id_rd != '0) & (w_lat != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (branch_taken) begin
      r_flush_cnt <= c_flush_reload;
    end else if (r_flush_cnt != '0) begin
      r_flush_cnt <= r_flush_cnt - c_fw'(1);
    end
  end

  logic [15:0] r_stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign busy_vec[r] = 1'b0;
    end else begin : g_cnt
      logic [c_cw-1:0] r_cnt;
      logic [c_cw-1:0] w_dec;

      assign w_dec       = (r_cnt != '0) ? r_cnt - c_cw'(1) : '0;
      assign busy_vec[r] = (r_cnt != '0);

      // A new writer never shortens an older, longer-latency pending write (WAW).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_set && (id_rd == AW'(r))) begin
          r_cnt <= (w_dec > w_lat) ? w_dec : w_lat;
        end else begin
          r_cnt <= w_dec;
        end
      end
    end
  end

endmodule

`default_nettype wire
